bin_counter_checker: RTL and testbench
======================================

Name: bin_counter_checker

Overview:
- Cycle-accurate RTL reference model and checker for an N-bit up/down binary counter with synchronous clear, parallel load, enable and max/min ticks.
- Sits beside the counter under test. It observes the same control inputs and the counter's q and tick outputs.
- Flags every mismatch, counts errors, and captures the first failing sample for self-checking benches and on-chip BIST.

Parameters:
N, 3, counter width in bits
CNT_W, 8, error counter width; the error counter saturates
STOP_ON_ERR, 0, when 1, checking halts at the first mismatch (HALT state)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
arm  in  1  level; when high, checking is enabled
syn_clr  in  1  control copied from the counter's input
load  in  1  control copied from the counter's input
en  in  1  control copied from the counter's input
up  in  1  control copied from the counter's input
d  in  N  load data copied from the counter's input
q  in  N  observed counter value
max_tick  in  1  observed max tick
min_tick  in  1  observed min tick
exp_q  out  N  model's expected count
mismatch  out  1  registered one-cycle pulse per failing cycle
err  out  1  sticky error flag
err_cnt  out  CNT_W  saturating count of failing cycles
first_q  out  N  observed q at the first failure
first_exp  out  N  expected q at the first failure
busy  out  1  high in the CHECK state

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: exp_q=0, mismatch=0, err=0, err_cnt=0, first_q=0, first_exp=0, busy=0, state=IDLE. Reset asserted mid-check aborts on that edge and clears everything, including err.
- Model update: the model updates every cycle in all states. It tracks the counter from its reset.
  - Priority is syn_clr > load > en.
  - syn_clr: exp_q<=0.
  - load: exp_q<=d.
  - en&up: exp_q<=exp_q+1, wrapping 2^N-1 to 0.
  - en&~up: exp_q<=exp_q-1, wrapping 0 to 2^N-1.
  - otherwise: hold.
- Expected ticks (combinational from exp_q): exp_max=(exp_q==2^N-1), exp_min=(exp_q==0).
- Compare (combinational, current cycle): fail = (q!=exp_q), OR'd with the tick comparison when the optional feature is enabled.
- FSM states and transitions:
  - IDLE: busy=0, no compare. Goes to CHECK when arm=1.
  - CHECK: busy=1.
    - Goes to IDLE when arm=0; err and the error counter are kept.
    - If fail: on the next edge mismatch=1 for 1 cycle, err<=1, err_cnt<=err_cnt+1 (held at 2^CNT_W-1 once reached).
    - If fail and err was 0: first_q<=q and first_exp<=exp_q. These are captured only once.
    - If fail and STOP_ON_ERR=1: goes to HALT.
  - HALT: busy=0, no further compare or capture; the model keeps tracking. Leaves only through rst.
- Latency: mismatch, err and err_cnt reflect cycle t at edge t+1. This gives exactly 1 cycle of latency from a bad sample.
- Simultaneous events: a fail and arm falling in the same cycle still records the error and goes to IDLE. syn_clr, load and en all high in one cycle resolves to clear.

Optional Feature:
- Macro BIN_COUNTER_CHECKER_TICK_CHECK_EN.
- Defined: fail also includes (max_tick!=exp_max)|(min_tick!=exp_min).
- Undefined: ticks are ignored, only q is compared, and max_tick/min_tick are left unconnected internally.

Test Plan:
- Reset then arm=1 with a correct counter: load d=3, clear, count up 10 cycles, pause 2, count down 10 -> mismatch never 1, err=0, err_cnt=0, exp_q tracks q each cycle (e.g. 7 then 0 at up-wrap).
- N=3, bench forces q=5 while exp_q=4 for one cycle in CHECK -> mismatch=1 exactly one cycle later, err=1, err_cnt=1, first_q=5, first_exp=4. A later second fault with q=2 vs 1 gives err_cnt=2 and first_* unchanged.
- STOP_ON_ERR=1, inject a fault -> state HALT, busy=0. Further faults leave err_cnt=1. Asserting rst for 1 cycle returns all outputs to reset values.
- CNT_W=2, continuous faults for 6 cycles -> err_cnt reads 1,2,3,3,3,3.
- Macro defined: q correct, max_tick held 0 while exp_q=7 -> mismatch=1. Macro undefined, same stimulus -> mismatch=0.
- Down-wrap with syn_clr, load and en all high in one cycle -> exp_q=0. Then en&~up -> exp_q=7, exp_max=1, exp_min=0.

Source files
------------

// File: rtl/bin_counter_checker.sv
// bin_counter_checker: cycle-accurate reference model and checker for an
// N-bit up/down binary counter (sync clear > load > enable, max/min ticks).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   arm                        checking enable (level)
//   syn_clr, load, en, up, d   copies of the counter's control inputs
//   q, max_tick, min_tick      observed counter outputs
//   exp_q                      model's expected count
//   mismatch                   registered one-cycle pulse per failing cycle
//   err, err_cnt               sticky error flag, saturating error count
//   first_q, first_exp         observed/expected q at the first failure
//   busy                       high while in the CHECK state
//
// Optional: define BIN_COUNTER_CHECKER_TICK_CHECK_EN to also compare ticks.
module bin_counter_checker #(
  parameter int unsigned N           = 3,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             syn_clr,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [N-1:0]     d,
  input  logic [N-1:0]     q,
  input  logic             max_tick,
  input  logic             min_tick,
  output logic [N-1:0]     exp_q,
  output logic             mismatch,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N-1:0]     first_q,
  output logic [N-1:0]     first_exp,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     exp_q_q, exp_q_d;
  logic             mismatch_q, mismatch_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [N-1:0]     first_q_q, first_q_d;
  logic [N-1:0]     first_exp_q, first_exp_d;
  logic             fail;

`ifdef BIN_COUNTER_CHECKER_TICK_CHECK_EN
  logic exp_max;
  logic exp_min;

  always_comb begin
    exp_max = (exp_q_q == '1);
    exp_min = (exp_q_q == '0);
    fail    = (q != exp_q_q) | (max_tick != exp_max) | (min_tick != exp_min);
  end
`else
  // Ticks are intentionally ignored in this build.
  logic unused_ticks;

  always_comb begin
    unused_ticks = max_tick | min_tick;
    fail         = (q != exp_q_q);
  end
`endif

  // Reference model: tracks the counter in every state, wraps naturally.
  always_comb begin
    exp_q_d = exp_q_q;
    if (syn_clr) begin
      exp_q_d = '0;
    end else if (load) begin
      exp_q_d = d;
    end else if (en) begin
      if (up) begin
        exp_q_d = exp_q_q + N'(1);
      end else begin
        exp_q_d = exp_q_q - N'(1);
      end
    end
  end

  // Checker FSM and error bookkeeping.
  always_comb begin
    state_d     = state_q;
    mismatch_d  = 1'b0;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    first_q_d   = first_q_q;
    first_exp_d = first_exp_q;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (fail) begin
          mismatch_d = 1'b1;
          err_d      = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          if (!err_q) begin
            first_q_d   = q;
            first_exp_d = exp_q_q;
          end
        end
        // Disarm wins over halting so a last-cycle failure still ends in IDLE.
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (fail && (STOP_ON_ERR != 0)) begin
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      exp_q_q     <= '0;
      mismatch_q  <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      first_q_q   <= '0;
      first_exp_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q_q     <= exp_q_d;
      mismatch_q  <= mismatch_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      first_q_q   <= first_q_d;
      first_exp_q <= first_exp_d;
    end
  end

  always_comb begin
    exp_q     = exp_q_q;
    mismatch  = mismatch_q;
    err       = err_q;
    err_cnt   = err_cnt_q;
    first_q   = first_q_q;
    first_exp = first_exp_q;
    busy      = (state_q == ST_CHECK);
  end

endmodule

// File: tb/tb_bin_counter_checker.sv
module tb_bin_counter_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic       syn_clr;
  logic       load;
  logic       en;
  logic       up;
  logic [2:0] d;
  logic [2:0] q;
  logic       force_tick;
  logic       max_force;
  logic       max_tick;
  logic       min_tick;

  logic [2:0] exp_q_a, first_q_a, first_exp_a;
  logic       mm_a, err_a, busy_a;
  logic [7:0] cnt_a;
  logic [2:0] exp_q_b, first_q_b, first_exp_b;
  logic       mm_b, err_b, busy_b;
  logic [7:0] cnt_b;
  logic [2:0] exp_q_c, first_q_c, first_exp_c;
  logic       mm_c, err_c, busy_c;
  logic [1:0] cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Ticks follow the observed q unless a test overrides max_tick.
  always_comb begin
    max_tick = force_tick ? max_force : (q == 3'd7);
    min_tick = (q == 3'd0);
  end

  bin_counter_checker #(.N(3), .CNT_W(8), .STOP_ON_ERR(0)) dut_a (
    .clk(clk), .rst(rst), .arm(arm), .syn_clr(syn_clr), .load(load), .en(en),
    .up(up), .d(d), .q(q), .max_tick(max_tick), .min_tick(min_tick),
    .exp_q(exp_q_a), .mismatch(mm_a), .err(err_a), .err_cnt(cnt_a),
    .first_q(first_q_a), .first_exp(first_exp_a), .busy(busy_a)
  );

  bin_counter_checker #(.N(3), .CNT_W(8), .STOP_ON_ERR(1)) dut_b (
    .clk(clk), .rst(rst), .arm(arm), .syn_clr(syn_clr), .load(load), .en(en),
    .up(up), .d(d), .q(q), .max_tick(max_tick), .min_tick(min_tick),
    .exp_q(exp_q_b), .mismatch(mm_b), .err(err_b), .err_cnt(cnt_b),
    .first_q(first_q_b), .first_exp(first_exp_b), .busy(busy_b)
  );

  bin_counter_checker #(.N(3), .CNT_W(2), .STOP_ON_ERR(0)) dut_c (
    .clk(clk), .rst(rst), .arm(arm), .syn_clr(syn_clr), .load(load), .en(en),
    .up(up), .d(d), .q(q), .max_tick(max_tick), .min_tick(min_tick),
    .exp_q(exp_q_c), .mismatch(mm_c), .err(err_c), .err_cnt(cnt_c),
    .first_q(first_q_c), .first_exp(first_exp_c), .busy(busy_c)
  );

  typedef struct {
    logic       syn_clr;
    logic       load;
    logic       en;
    logic       up;
    logic [2:0] d;
    logic [2:0] q;
    logic [2:0] exp_q;
    logic       mm;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic c, input logic l, input logic e,
                              input logic u, input logic [2:0] dd,
                              input logic [2:0] qq, input logic [2:0] eq,
                              input logic m, input logic [7:0] cn);
    vec_t v;
    v.syn_clr = c;  v.load = l;  v.en = e;  v.up = u;  v.d = dd;
    v.q = qq;  v.exp_q = eq;  v.mm = m;  v.cnt = cn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic c, input logic l, input logic e,
                     input logic u, input logic [2:0] dd, input logic [2:0] qq);
    syn_clr = c;  load = l;  en = e;  up = u;  d = dd;  q = qq;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [1:0] sat_exp [6];
  logic       tick_mm_exp;

  initial begin
    rst = 1'b1;  arm = 1'b0;  force_tick = 1'b0;  max_force = 1'b0;
    ctl(0, 0, 0, 0, 3'd0, 3'd0);

    // Correct counter: load 3, clear, up x10 (wraps 7->0), hold x2, down x10.
    tbl.push_back(mk(0,1,0,0,3'd3, 3'd0, 3'd3,0,0));
    tbl.push_back(mk(1,0,0,0,3'd0, 3'd3, 3'd0,0,0));
    tbl.push_back(mk(0,0,1,1,3'd0, 3'd0, 3'd1,0,0));
    tbl.push_back(mk(0,0,1,1,3'd0, 3'd1, 3'd2,0,0));
    tbl.push_back(mk(0,0,1,1,3'd0, 3'd2, 3'd3,0,0));
    tbl.push_back(mk(0,0,1,1,3'd0, 3'd3, 3'd4,0,0));
    tbl.push_back(mk(0,0,1,1,3'd0, 3'd4, 3'd5,0,0));
    tbl.push_back(mk(0,0,1,1,3'd0, 3'd5, 3'd6,0,0));
    tbl.push_back(mk(0,0,1,1,3'd0, 3'd6, 3'd7,0,0));
    tbl.push_back(mk(0,0,1,1,3'd0, 3'd7, 3'd0,0,0));
    tbl.push_back(mk(0,0,1,1,3'd0, 3'd0, 3'd1,0,0));
    tbl.push_back(mk(0,0,1,1,3'd0, 3'd1, 3'd2,0,0));
    tbl.push_back(mk(0,0,0,1,3'd0, 3'd2, 3'd2,0,0));
    tbl.push_back(mk(0,0,0,1,3'd0, 3'd2, 3'd2,0,0));
    tbl.push_back(mk(0,0,1,0,3'd0, 3'd2, 3'd1,0,0));
    tbl.push_back(mk(0,0,1,0,3'd0, 3'd1, 3'd0,0,0));
    tbl.push_back(mk(0,0,1,0,3'd0, 3'd0, 3'd7,0,0));
    tbl.push_back(mk(0,0,1,0,3'd0, 3'd7, 3'd6,0,0));
    tbl.push_back(mk(0,0,1,0,3'd0, 3'd6, 3'd5,0,0));
    tbl.push_back(mk(0,0,1,0,3'd0, 3'd5, 3'd4,0,0));
    tbl.push_back(mk(0,0,1,0,3'd0, 3'd4, 3'd3,0,0));
    tbl.push_back(mk(0,0,1,0,3'd0, 3'd3, 3'd2,0,0));
    tbl.push_back(mk(0,0,1,0,3'd0, 3'd2, 3'd1,0,0));
    tbl.push_back(mk(0,0,1,0,3'd0, 3'd1, 3'd0,0,0));
    // Faults: q=5 vs 4, then q=2 vs 1.
    tbl.push_back(mk(0,1,0,0,3'd4, 3'd0, 3'd4,0,0));
    tbl.push_back(mk(0,0,0,0,3'd0, 3'd5, 3'd4,1,1));
    tbl.push_back(mk(0,0,0,0,3'd0, 3'd4, 3'd4,0,1));
    tbl.push_back(mk(0,1,0,0,3'd1, 3'd4, 3'd1,0,1));
    tbl.push_back(mk(0,0,0,0,3'd0, 3'd2, 3'd1,1,2));
    tbl.push_back(mk(0,0,0,0,3'd0, 3'd1, 3'd1,0,2));

    step();
    step();
    rst = 1'b0;

    chk("rst_exp_q_a", exp_q_a, 0);      chk("rst_mm_a", mm_a, 0);
    chk("rst_err_a", err_a, 0);          chk("rst_cnt_a", cnt_a, 0);
    chk("rst_first_q_a", first_q_a, 0);  chk("rst_first_exp_a", first_exp_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_exp_q_b", exp_q_b, 0);      chk("rst_mm_b", mm_b, 0);
    chk("rst_err_b", err_b, 0);          chk("rst_cnt_b", cnt_b, 0);
    chk("rst_first_q_b", first_q_b, 0);  chk("rst_first_exp_b", first_exp_b, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_exp_q_c", exp_q_c, 0);      chk("rst_mm_c", mm_c, 0);
    chk("rst_err_c", err_c, 0);          chk("rst_cnt_c", cnt_c, 0);
    chk("rst_first_q_c", first_q_c, 0);  chk("rst_first_exp_c", first_exp_c, 0);
    chk("rst_busy_c", busy_c, 0);

    arm = 1'b1;
    step();
    chk("arm_busy_a", busy_a, 1);

    foreach (tbl[i]) begin
      ctl(tbl[i].syn_clr, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].d, tbl[i].q);
      step();
      chk($sformatf("vec%0d_exp_q", i), exp_q_a, tbl[i].exp_q);
      chk($sformatf("vec%0d_mismatch", i), mm_a, tbl[i].mm);
      chk($sformatf("vec%0d_err_cnt", i), cnt_a, tbl[i].cnt);
      chk($sformatf("vec%0d_busy", i), busy_a, 1);
    end
    chk("fault_err_a", err_a, 1);
    chk("fault_first_q_a", first_q_a, 5);
    chk("fault_first_exp_a", first_exp_a, 4);

    // STOP_ON_ERR instance: halt on first fault, ignore later ones.
    ctl(0, 0, 0, 0, 3'd0, 3'd0);
    pulse_reset();
    step();
    chk("halt_busy_before", busy_b, 1);
    q = 3'd3;
    step();
    chk("halt_mm", mm_b, 1);
    chk("halt_err", err_b, 1);
    chk("halt_cnt", cnt_b, 1);
    chk("halt_busy", busy_b, 0);
    chk("halt_first_q", first_q_b, 3);
    chk("halt_first_exp", first_exp_b, 0);
    q = 3'd6;
    step();
    chk("halt_mm_after", mm_b, 0);
    chk("halt_cnt_after", cnt_b, 1);
    chk("halt_first_q_after", first_q_b, 3);
    ctl(0, 0, 1, 1, 3'd0, 3'd0);
    step();
    chk("halt_model_tracks", exp_q_b, 1);
    chk("halt_busy_stays", busy_b, 0);
    ctl(0, 0, 0, 0, 3'd0, 3'd0);
    rst = 1'b1;
    step();
    chk("halt_rst_exp_q", exp_q_b, 0);
    chk("halt_rst_err", err_b, 0);
    chk("halt_rst_cnt", cnt_b, 0);
    chk("halt_rst_first_q", first_q_b, 0);
    chk("halt_rst_first_exp", first_exp_b, 0);
    chk("halt_rst_busy", busy_b, 0);
    rst = 1'b0;
    step();
    chk("halt_rearm_busy", busy_b, 1);

    // CNT_W=2 instance: continuous faults saturate at 3.
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    pulse_reset();
    step();
    q = 3'd5;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("sat%0d_cnt", i), cnt_c, sat_exp[i]);
      chk($sformatf("sat%0d_mm", i), mm_c, 1);
    end
    chk("sat_first_q", first_q_c, 5);

    // Tick check: q correct at 7 but max_tick held low.
    q = 3'd0;
    pulse_reset();
    step();
    ctl(0, 1, 0, 0, 3'd7, 3'd0);
    step();
    chk("tick_exp_q", exp_q_a, 7);
    chk("tick_load_mm", mm_a, 0);
    ctl(0, 0, 0, 0, 3'd0, 3'd7);
    force_tick = 1'b1;
    max_force  = 1'b0;
`ifdef BIN_COUNTER_CHECKER_TICK_CHECK_EN
    tick_mm_exp = 1'b1;
`else
    tick_mm_exp = 1'b0;
`endif
    step();
    chk("tick_mm", mm_a, tick_mm_exp);
    force_tick = 1'b0;

    // Clear wins over load/en, then down-wrap 0 -> 7.
    ctl(0, 0, 0, 0, 3'd0, 3'd0);
    pulse_reset();
    step();
    ctl(1, 1, 1, 0, 3'd5, 3'd0);
    step();
    chk("prio_exp_q", exp_q_a, 0);
    chk("prio_mm", mm_a, 0);
    ctl(0, 0, 1, 0, 3'd0, 3'd0);
    step();
    chk("wrap_exp_q", exp_q_a, 7);
    chk("wrap_mm", mm_a, 0);
    chk("wrap_err", err_a, 0);

    // Fault and disarm together: recorded, then IDLE stops comparing.
    ctl(0, 0, 0, 0, 3'd0, 3'd3);
    arm = 1'b0;
    step();
    chk("disarm_mm", mm_a, 1);
    chk("disarm_err", err_a, 1);
    chk("disarm_cnt", cnt_a, 1);
    chk("disarm_busy", busy_a, 0);
    step();
    chk("idle_mm", mm_a, 0);
    chk("idle_cnt", cnt_a, 1);
    chk("idle_err_kept", err_a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
